// File: rtl/dct_mac_seq_if.sv
// Control bundle between a DCT MAC sequencer and the block that feeds rows
// into it and collects the finished accumulator.
interface dct_mac_seq_if #(
  parameter int CNT_W = 3
);
  logic             ena;
  logic             start;
  logic             busy;
  logic [CNT_W-1:0] coef_sel;
  logic             mult_en;
  logic             acc_en;
  logic             acc_clr;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;

  // Requester / consumer side.
  modport master (
    output ena, start, dout_ready,
    input  busy, coef_sel, mult_en, acc_en, acc_clr, dout_valid, overrun
  );

  // Sequencer side.
  modport slave (
    input  ena, start, dout_ready,
    output busy, coef_sel, mult_en, acc_en, acc_clr, dout_valid, overrun
  );
endinterface

// File: rtl/dct_mac_seq.sv
// Sequencer for one DCT MAC unit: on each accepted start it issues TAPS
// coefficient/sample selects with the product-stage enable, delays that
// enable (and a tap-0 marker) by MULT_LAT cycles to drive the accumulator,
// then holds the finished result under a valid/ready handshake.
// All outputs are registered; ena low freezes everything.
module dct_mac_seq #(
  parameter int TAPS     = 8,
  parameter int CNT_W    = 3,
  parameter int MULT_LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dct_mac_seq_if.slave bus
);

  localparam int                DCNT_W     = 2;
  localparam logic [CNT_W-1:0]  LAST_TAP   = CNT_W'(TAPS - 1);
  localparam logic [DCNT_W-1:0] LAST_DRAIN = DCNT_W'(MULT_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_HOLD
  } state_e;

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    coef_q,    coef_d;
  logic [DCNT_W-1:0]   dcnt_q,    dcnt_d;
  logic                mult_en_q, mult_en_d;
  logic                tap0_q,    tap0_d;
  logic                busy_q,    busy_d;
  logic                valid_q,   valid_d;
  logic                overrun_q, overrun_d;
  logic [MULT_LAT-1:0] acc_sr_q,  acc_sr_d;
  logic [MULT_LAT-1:0] clr_sr_q,  clr_sr_d;

  // Next-state and registered-output values; nothing moves while ena is low.
  always_comb begin
    state_d   = state_q;
    coef_d    = coef_q;
    dcnt_d    = dcnt_q;
    mult_en_d = mult_en_q;
    tap0_d    = tap0_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (bus.ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d   = S_ISSUE;
            coef_d    = '0;
            mult_en_d = 1'b1;
            tap0_d    = 1'b1;
            busy_d    = 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.start) overrun_d = 1'b1;
          tap0_d = 1'b0;
          if (coef_q == LAST_TAP) begin
            state_d   = S_DRAIN;
            coef_d    = '0;
            mult_en_d = 1'b0;
            dcnt_d    = '0;
          end else begin
            coef_d = coef_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (bus.start) overrun_d = 1'b1;
          if (dcnt_q == LAST_DRAIN) begin
            state_d = S_HOLD;
            busy_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.dout_ready) begin
            valid_d = 1'b0;
            if (bus.start) begin
              // Back-to-back: first tap issues in the very next cycle.
              state_d   = S_ISSUE;
              coef_d    = '0;
              mult_en_d = 1'b1;
              tap0_d    = 1'b1;
              busy_d    = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (bus.start) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Delay lines matching the multiplier latency: product enable and tap-0 marker.
  always_comb begin
    acc_sr_d = acc_sr_q;
    clr_sr_d = clr_sr_q;
    if (bus.ena) begin
      acc_sr_d[0] = mult_en_q;
      clr_sr_d[0] = tap0_q;
      for (int i = 1; i < MULT_LAT; i++) begin
        acc_sr_d[i] = acc_sr_q[i-1];
        clr_sr_d[i] = clr_sr_q[i-1];
      end
    end
  end

  // State and output registers; reset discards any partial result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      coef_q    <= '0;
      dcnt_q    <= '0;
      mult_en_q <= 1'b0;
      tap0_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      acc_sr_q  <= '0;
      clr_sr_q  <= '0;
    end else begin
      state_q   <= state_d;
      coef_q    <= coef_d;
      dcnt_q    <= dcnt_d;
      mult_en_q <= mult_en_d;
      tap0_q    <= tap0_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      acc_sr_q  <= acc_sr_d;
      clr_sr_q  <= clr_sr_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.coef_sel   = coef_q;
  assign bus.mult_en    = mult_en_q;
  assign bus.acc_en     = acc_sr_q[MULT_LAT-1];
  assign bus.acc_clr    = clr_sr_q[MULT_LAT-1];
  assign bus.dout_valid = valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/dct_mac_seq.md
# dct_mac_seq

Sequencer for one DCT MAC unit in the forward-DCT datapath of the JPEG encoder. On each `start` it steps the unit through TAPS multiply-accumulate cycles:
- drives the coefficient/sample select;
- drives the enable of the registered product stage (`mult_res`);
- drives the accumulator load/add controls;
- presents the finished accumulator with a valid/ready handshake.

One instance sits beside each MAC unit in every DCT block.

## Interface
- `TAPS`, 8, products accumulated per result (≥2)
- `CNT_W`, 3, width of `coef_sel` (2^CNT_W ≥ TAPS)
- `MULT_LAT`, 1, register stages between `mult_en` and the product at the accumulator input (1..4)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `ena`  in  1  clock enable; low freezes all state and holds all outputs
- `start`  in  1  single-cycle request: a new input row is stable
- `busy`  out  1  high from start acceptance until `dout_valid` rises
- `coef_sel`  out  CNT_W  tap index to the coefficient ROM and sample mux
- `mult_en`  out  1  enable of the `mult_res` DFFE stage
- `acc_en`  out  1  accumulator update enable
- `acc_clr`  out  1  with `acc_en`: accumulator loads the product instead of adding it
- `dout_valid`  out  1  accumulator holds a complete result
- `dout_ready`  in  1  consumer accepts the result
- `overrun`  out  1  sticky: a `start` was dropped

## Operation
- States:
  - IDLE: waiting for a request.
  - ISSUE: TAPS cycles, `mult_en` high.
  - DRAIN: MULT_LAT cycles waiting for the last product to reach the accumulator.
  - HOLD: `dout_valid` high.
- Transitions:
  - IDLE→ISSUE on `start`.
  - ISSUE→DRAIN after TAPS cycles.
  - DRAIN→HOLD after MULT_LAT cycles.
  - HOLD→IDLE on `dout_ready`. If `start` is also high in that cycle, HOLD→ISSUE (back-to-back).
- In ISSUE:
  - `coef_sel` counts 0..TAPS-1, one per cycle.
  - `mult_en`=1.
- `acc_en` is `mult_en` delayed by exactly MULT_LAT cycles, produced by a MULT_LAT-deep shift register.
- `acc_clr` is the "tap 0" marker delayed the same way, so it is high only with the first `acc_en` of each result.
- `coef_sel` is 0 outside ISSUE.
- `start` is accepted only in IDLE, or in HOLD when `dout_ready`=1 in the same cycle. In any other state `start` is dropped and `overrun` sets.
- `overrun` clears only on reset.
- `dout_valid` stays high in HOLD until `dout_ready`; the accumulator is not touched while held (`acc_en`=0).
- `ena`=0 is a pure freeze:
  - No state, counter or shift-register change.
  - `start` and `dout_ready` are ignored that cycle and never set `overrun`.
- Reset (asynchronous, any state, including mid-ISSUE):
  - State → IDLE.
  - `coef_sel`=0.
  - `busy`, `mult_en`, `acc_en`, `acc_clr`, `dout_valid`, `overrun` = 0.
  - Pipeline shift registers cleared.
  - A partial result is discarded.

## Timing
All outputs are registered. Edge E0 samples an accepted `start`.
- After E0 through after E(TAPS-1): `mult_en`=1, `coef_sel`=k after edge Ek; `busy`=1.
- After edge E(k+MULT_LAT), k=0..TAPS-1: `acc_en`=1. `acc_clr`=1 only for k=0.
- After edge E(TAPS+MULT_LAT): `dout_valid`=1, `busy`=0, `acc_en`=0.
  - Default latency is 9 edges from the start sample to valid.
- `dout_valid` falls on the edge where `dout_ready`=1 is sampled.
- On a back-to-back start, `mult_en`=1 and `coef_sel`=0 in the next cycle, so there is no idle bubble.
- Throughput: one result per TAPS+MULT_LAT+1 cycles when `dout_ready` is held high.
- Every `ena`=0 cycle stretches all of the above by exactly one cycle.

## Test plan
1. Reset, then a `start` pulse with `dout_ready`=1 (defaults) -> `coef_sel` 0..7 on cycles 1..8; `acc_en` on cycles 2..9 with `acc_clr` only on cycle 2; `dout_valid` on cycle 10 for one cycle; `overrun`=0.
2. `dout_ready`=0 for 5 cycles after valid -> `dout_valid` held 5 cycles, `acc_en`=0 throughout. Raise `dout_ready` together with `start` -> `mult_en`=1, `coef_sel`=0 next cycle.
3. `start` pulsed during ISSUE (cycle 4) -> ignored, sequence unchanged, `overrun`=1 thereafter.
4. `ena` low for 3 cycles mid-ISSUE at `coef_sel`=3 -> all outputs frozen. On resume, `coef_sel` continues at 4 and `dout_valid` arrives 3 cycles late (cycle 13).
5. `rst` asserted asynchronously at `coef_sel`=5 -> all outputs 0 immediately. After release, a new `start` gives the full 0..7 sequence with `acc_clr` on the first `acc_en`.
6. MULT_LAT=3, TAPS=4 -> `acc_en` on cycles 4..7, `dout_valid` on cycle 8. Checked with a reference model that accumulates products and compares against the expected sum.
